// File: rtl/branch_resolve_unit_if.sv
// Execute-stage branch resolution bus: instruction/operands in, resolved outcome out,
// plus the fetch-side BHT lookup.
interface branch_resolve_unit_if #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned CNT_WIDTH = 32
);
  logic                 in_valid;
  logic                 stall;
  logic                 flush;
  logic [4:0]           opcode_in6to2;
  logic [2:0]           func3_in;
  logic [XLEN-1:0]      pc_in;
  logic [XLEN-1:0]      imm_in;
  logic [XLEN-1:0]      rs1_in;
  logic [XLEN-1:0]      rs2_in;
  logic                 pred_taken_in;
  logic [XLEN-1:0]      pred_target_in;
  logic [XLEN-1:0]      fetch_pc;
  logic                 fetch_pred_taken;
  logic                 out_valid;
  logic                 branchtaken_out;
  logic                 redirect_out;
  logic [XLEN-1:0]      redirect_pc;
  logic [XLEN-1:0]      link_out;
  logic                 illegal_out;
  logic [CNT_WIDTH-1:0] branch_cnt;
  logic [CNT_WIDTH-1:0] mispredict_cnt;

  modport master (
    output in_valid, stall, flush, opcode_in6to2, func3_in, pc_in, imm_in, rs1_in, rs2_in,
           pred_taken_in, pred_target_in, fetch_pc,
    input  fetch_pred_taken, out_valid, branchtaken_out, redirect_out, redirect_pc, link_out,
           illegal_out, branch_cnt, mispredict_cnt
  );

  modport slave (
    input  in_valid, stall, flush, opcode_in6to2, func3_in, pc_in, imm_in, rs1_in, rs2_in,
           pred_taken_in, pred_target_in, fetch_pc,
    output fetch_pred_taken, out_valid, branchtaken_out, redirect_out, redirect_pc, link_out,
           illegal_out, branch_cnt, mispredict_cnt
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Registered branch/jump resolution: evaluates conditions, detects mispredicts, and owns
// the 2-bit BHT read by fetch plus saturating branch/mispredict counters.
module branch_resolve_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  branch_resolve_unit_if.slave bus
);
  localparam int unsigned IDX      = $clog2(BHT_ENTRIES);
  localparam logic [4:0]  OpBranch = 5'b11000;
  localparam logic [4:0]  OpJal    = 5'b11011;
  localparam logic [4:0]  OpJalr   = 5'b11001;

  logic                 is_branch, is_jal, is_jalr, illegal, legal_branch, cond;
  logic                 taken, redirect;
  logic [XLEN-1:0]      target, pc_plus4, jalr_sum;
  logic [IDX-1:0]       upd_idx;
  logic [1:0]           entry;

  logic                 valid_q, valid_d, taken_q, taken_d;
  logic                 redirect_q, redirect_d, illegal_q, illegal_d;
  logic [XLEN-1:0]      redirect_pc_q, redirect_pc_d, link_q, link_d;
  logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d, mispredict_cnt_q, mispredict_cnt_d;
  logic [BHT_ENTRIES-1:0][1:0] bht_q, bht_d;

  logic unused_fetch;
  assign unused_fetch = ^{bus.fetch_pc[XLEN-1:IDX+2], bus.fetch_pc[1:0]};

  always_comb begin
    is_branch    = (bus.opcode_in6to2 == OpBranch);
    is_jal       = (bus.opcode_in6to2 == OpJal);
    is_jalr      = (bus.opcode_in6to2 == OpJalr);
    illegal      = is_branch && (bus.func3_in[2:1] == 2'b01);
    legal_branch = is_branch && !illegal;

    case (bus.func3_in)
      3'b000:  cond = (bus.rs1_in == bus.rs2_in);
      3'b001:  cond = (bus.rs1_in != bus.rs2_in);
      3'b100:  cond = ($signed(bus.rs1_in) < $signed(bus.rs2_in));
      3'b101:  cond = ($signed(bus.rs1_in) >= $signed(bus.rs2_in));
      3'b110:  cond = (bus.rs1_in < bus.rs2_in);
      3'b111:  cond = (bus.rs1_in >= bus.rs2_in);
      default: cond = 1'b0;
    endcase

    taken    = is_jal || is_jalr || (legal_branch && cond);
    pc_plus4 = bus.pc_in + XLEN'(4);
    jalr_sum = bus.rs1_in + bus.imm_in;
    target   = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (bus.pc_in + bus.imm_in);
    // Illegal branches are left to the trap path rather than redirected here.
    redirect = (legal_branch || is_jal || is_jalr) &&
               ((taken != bus.pred_taken_in) || (taken && (target != bus.pred_target_in)));
  end

  always_comb begin
    valid_d          = valid_q;
    taken_d          = taken_q;
    redirect_d       = redirect_q;
    illegal_d        = illegal_q;
    redirect_pc_d    = redirect_pc_q;
    link_d           = link_q;
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    bht_d            = bht_q;
    upd_idx          = bus.pc_in[IDX+1:2];
    entry            = bht_q[upd_idx];

    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (!bus.stall) begin
      valid_d = bus.in_valid;
      if (bus.in_valid) begin
        taken_d       = taken;
        redirect_d    = redirect;
        illegal_d     = illegal;
        redirect_pc_d = taken ? target : pc_plus4;
        link_d        = (is_jal || is_jalr) ? pc_plus4 : '0;
        if (legal_branch) begin
          if (taken && entry != 2'b11) begin
            bht_d[upd_idx] = entry + 2'b01;
          end else if (!taken && entry != 2'b00) begin
            bht_d[upd_idx] = entry - 2'b01;
          end
          if (!(&branch_cnt_q)) branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
        end
        if (redirect && !(&mispredict_cnt_q)) begin
          mispredict_cnt_d = mispredict_cnt_q + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q          <= 1'b0;
      taken_q          <= 1'b0;
      redirect_q       <= 1'b0;
      illegal_q        <= 1'b0;
      redirect_pc_q    <= '0;
      link_q           <= '0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
      bht_q            <= {BHT_ENTRIES{2'b01}};
    end else begin
      valid_q          <= valid_d;
      taken_q          <= taken_d;
      redirect_q       <= redirect_d;
      illegal_q        <= illegal_d;
      redirect_pc_q    <= redirect_pc_d;
      link_q           <= link_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
      bht_q            <= bht_d;
    end
  end

  assign bus.fetch_pred_taken = bht_q[bus.fetch_pc[IDX+1:2]][1];
  assign bus.out_valid        = valid_q;
  assign bus.branchtaken_out  = valid_q && taken_q;
  assign bus.redirect_out     = valid_q && redirect_q;
  assign bus.redirect_pc      = redirect_pc_q;
  assign bus.link_out         = link_q;
  assign bus.illegal_out      = illegal_q;
  assign bus.branch_cnt       = branch_cnt_q;
  assign bus.mispredict_cnt   = mispredict_cnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed plus randomized bench for branch_resolve_unit against a behavioural model.
module tb_branch_resolve_unit;
  localparam int unsigned X   = 32;
  localparam int unsigned N   = 64;
  localparam int unsigned CW  = 4;
  localparam int unsigned IW  = 6;
  localparam int unsigned MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.XLEN(X), .CNT_WIDTH(CW)) bus ();

  branch_resolve_unit #(.XLEN(X), .BHT_ENTRIES(N), .CNT_WIDTH(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  bit          m_valid, m_taken, m_redir, m_ill;
  logic [31:0] m_rpc, m_link;
  int          m_bht[N];
  int unsigned m_bcnt, m_mcnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_valid = 0; m_taken = 0; m_redir = 0; m_ill = 0;
    m_rpc = 0; m_link = 0; m_bcnt = 0; m_mcnt = 0;
    for (int i = 0; i < N; i++) m_bht[i] = 1;
  endtask

  // Model of one rising edge using the inputs currently applied.
  task automatic model_edge();
    logic [31:0] pc, imm, a, b, tgt;
    logic [4:0]  op;
    logic [2:0]  f3;
    bit          br, jal, jalr, ill, t, ctl;
    int          i;
    pc = bus.pc_in; imm = bus.imm_in; a = bus.rs1_in; b = bus.rs2_in;
    op = bus.opcode_in6to2; f3 = bus.func3_in;
    if (bus.flush) begin
      m_valid = 0;
    end else if (!bus.stall) begin
      if (!bus.in_valid) begin
        m_valid = 0;
      end else begin
        br   = (op == 5'b11000);
        jal  = (op == 5'b11011);
        jalr = (op == 5'b11001);
        ill  = br && (f3 == 3'd2 || f3 == 3'd3);
        case (f3)
          3'd0: t = (a == b);
          3'd1: t = (a != b);
          3'd4: t = ($signed(a) < $signed(b));
          3'd5: t = !($signed(a) < $signed(b));
          3'd6: t = (a < b);
          3'd7: t = !(a < b);
          default: t = 0;
        endcase
        if (!br || ill) t = 0;
        if (jal || jalr) t = 1;
        tgt = jalr ? ((a + imm) & 32'hFFFF_FFFE) : (pc + imm);
        ctl = (br && !ill) || jal || jalr;
        m_redir = ctl && ((t != bus.pred_taken_in) || (t && tgt != bus.pred_target_in));
        m_taken = t;
        m_ill   = ill;
        m_rpc   = t ? tgt : pc + 4;
        m_link  = (jal || jalr) ? pc + 4 : 32'h0;
        m_valid = 1;
        if (br && !ill) begin
          i = int'(pc[IW+1:2]);
          if (t) m_bht[i] = (m_bht[i] == 3) ? 3 : m_bht[i] + 1;
          else   m_bht[i] = (m_bht[i] == 0) ? 0 : m_bht[i] - 1;
          if (m_bcnt < MAX) m_bcnt++;
        end
        if (m_redir && m_mcnt < MAX) m_mcnt++;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] fp;
    fp = bus.fetch_pc;
    check({tag, ".valid"}, bus.out_valid, m_valid);
    check({tag, ".taken"}, bus.branchtaken_out, m_valid && m_taken);
    check({tag, ".redir"}, bus.redirect_out, m_valid && m_redir);
    check({tag, ".rpc"}, bus.redirect_pc, m_rpc);
    check({tag, ".link"}, bus.link_out, m_link);
    check({tag, ".illegal"}, bus.illegal_out, m_ill);
    check({tag, ".bcnt"}, bus.branch_cnt, m_bcnt);
    check({tag, ".mcnt"}, bus.mispredict_cnt, m_mcnt);
    check({tag, ".fpred"}, bus.fetch_pred_taken, m_bht[int'(fp[IW+1:2])] >= 2);
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic set_instr(input logic [4:0] op, input logic [2:0] f3, input logic [31:0] pc,
                           input logic [31:0] imm, input logic [31:0] a, input logic [31:0] b,
                           input logic pt, input logic [31:0] ptgt);
    bus.in_valid = 1; bus.opcode_in6to2 = op; bus.func3_in = f3; bus.pc_in = pc;
    bus.imm_in = imm; bus.rs1_in = a; bus.rs2_in = b;
    bus.pred_taken_in = pt; bus.pred_target_in = ptgt;
  endtask

  initial begin
    logic [31:0] pc, imm, a;
    int r;
    bus.in_valid = 0; bus.stall = 0; bus.flush = 0; bus.opcode_in6to2 = 0; bus.func3_in = 0;
    bus.pc_in = 0; bus.imm_in = 0; bus.rs1_in = 0; bus.rs2_in = 0;
    bus.pred_taken_in = 0; bus.pred_target_in = 0; bus.fetch_pc = 32'h104;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1;

    // BEQ mispredicted as not taken
    set_instr(5'b11000, 3'b000, 32'h100, 32'h20, 5, 5, 0, 0);
    step("beq");
    check("beq.taken_k", bus.branchtaken_out, 1);
    check("beq.rpc_k", bus.redirect_pc, 32'h120);
    check("beq.mcnt_k", bus.mispredict_cnt, 1);
    bus.in_valid = 0;
    step("idle");
    check("idle.valid_k", bus.out_valid, 0);

    set_instr(5'b11000, 3'b100, 32'h140, 32'h8, 32'hFFFF_FFFF, 1, 1, 32'h148);
    step("blt");
    check("blt.taken_k", bus.branchtaken_out, 1);
    set_instr(5'b11000, 3'b110, 32'h140, 32'h8, 32'hFFFF_FFFF, 1, 0, 32'h148);
    step("bltu");
    check("bltu.taken_k", bus.branchtaken_out, 0);
    check("bltu.redir_k", bus.redirect_out, 0);

    set_instr(5'b11001, 3'b000, 32'h200, 32'h4, 32'h1001, 0, 1, 32'h1004);
    step("jalr");
    check("jalr.redir_k", bus.redirect_out, 0);
    check("jalr.rpc_k", bus.redirect_pc, 32'h1004);
    check("jalr.link_k", bus.link_out, 32'h204);

    // BHT training on one index; lookup shows the pre-update value until the edge
    bus.fetch_pc = 32'h104;
    check("bht.pre_k", bus.fetch_pred_taken, 0);
    set_instr(5'b11000, 3'b000, 32'h104, 32'h40, 7, 7, 1, 32'h144);
    step("bht1");
    check("bht1.fpred_k", bus.fetch_pred_taken, 1);
    step("bht2");
    step("bht3");

    // Stall freezes everything, then flush kills an incoming branch
    set_instr(5'b11000, 3'b001, 32'h108, 32'h10, 1, 2, 0, 0);
    step("cap");
    bus.stall = 1;
    set_instr(5'b11011, 3'b000, 32'h300, 32'h80, 0, 0, 0, 0);
    repeat (3) step("stall");
    check("stall.link_k", bus.link_out, 0);
    bus.stall = 0; bus.flush = 1; bus.fetch_pc = 32'h108;
    set_instr(5'b11000, 3'b001, 32'h108, 32'h10, 1, 2, 0, 0);
    step("flush");
    check("flush.valid_k", bus.out_valid, 0);
    bus.flush = 0;

    // Reset asserted mid-stall after two branches
    set_instr(5'b11000, 3'b101, 32'h10c, 32'h10, 9, 3, 0, 0);
    step("pre1");
    set_instr(5'b11000, 3'b111, 32'h110, 32'h10, 1, 3, 0, 0);
    step("pre2");
    bus.stall = 1;
    #3;
    rst_n = 0;
    #1;
    m_reset();
    check_all("rst_mid");
    bus.fetch_pc = 32'h104;
    #1;
    check("rst_mid.bht_k", bus.fetch_pred_taken, 0);
    @(posedge clk);
    #1;
    rst_n = 1; bus.stall = 0;

    set_instr(5'b11000, 3'b010, 32'h10c, 32'h10, 4, 4, 0, 0);
    step("ill");
    check("ill.illegal_k", bus.illegal_out, 1);
    check("ill.taken_k", bus.branchtaken_out, 0);
    check("ill.bcnt_k", bus.branch_cnt, 0);

    for (int n = 0; n < 400; n++) begin
      r   = $urandom_range(0, 9);
      pc  = 32'h1000 | (32'($urandom_range(0, 31)) << 2);
      imm = $urandom & 32'h0000_1FFE;
      if ($urandom_range(0, 1) == 1) imm = -imm;
      a   = $urandom;
      set_instr((r < 6) ? 5'b11000 : (r == 6) ? 5'b11011 : (r == 7) ? 5'b11001
                                                          : 5'($urandom),
                3'($urandom), pc, imm, a, ($urandom_range(0, 2) == 0) ? a : $urandom,
                1'($urandom), ($urandom_range(0, 1) == 1) ? pc + imm : $urandom);
      bus.in_valid = ($urandom_range(0, 7) != 0);
      bus.stall    = ($urandom_range(0, 7) == 0);
      bus.flush    = ($urandom_range(0, 15) == 0);
      bus.fetch_pc = ($urandom_range(0, 1) == 1) ? pc : $urandom;
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
